// File: rtl/bomb_countdown_ctrl_pkg.sv
// bomb_pkg: encodings shared by the countdown controller and bomb_register.
//   NONE/LOAD/INCR/DECR : register ctrl opcodes (2 bits)
//   state_t             : controller state encoding (2 bits)
package bomb_pkg;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] INCR = 2'd2;
  localparam logic [1:0] DECR = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    EXPLODED = 2'd2,
    DEFUSED  = 2'd3
  } state_t;

endpackage

// File: rtl/bomb_countdown_ctrl_if.sv
// Bus between the countdown controller and its parent.
//   tick, btn_*, code_in : one-cycle input pulses / code sampled with btn_disarm
//   cnt_value            : register data_out fed back to the controller
//   cnt_ctrl, cnt_load   : register ctrl / data_in driven by the controller
//   armed, exploded, defused, attempts_left : controller status
// master = parent side (drives inputs), slave = controller side.
interface bomb_countdown_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             btn_inc;
  logic             btn_dec;
  logic             btn_arm;
  logic             btn_disarm;
  logic             btn_clear;
  logic [3:0]       code_in;
  logic [WIDTH-1:0] cnt_value;
  logic [1:0]       cnt_ctrl;
  logic [WIDTH-1:0] cnt_load;
  logic             armed;
  logic             exploded;
  logic             defused;
  logic [1:0]       attempts_left;

  modport master (
    output tick, btn_inc, btn_dec, btn_arm, btn_disarm, btn_clear, code_in, cnt_value,
    input  cnt_ctrl, cnt_load, armed, exploded, defused, attempts_left
  );

  modport slave (
    input  tick, btn_inc, btn_dec, btn_arm, btn_disarm, btn_clear, code_in, cnt_value,
    output cnt_ctrl, cnt_load, armed, exploded, defused, attempts_left
  );
endinterface

// File: rtl/bomb_countdown_ctrl.sv
// Countdown bomb controller: sets time, arms, counts down per tick, handles
// code-entry disarm with a halve-the-time penalty per wrong code.
// Ports:
//   clk          : rising-edge clock
//   async_nreset : asynchronous active-low reset
//   bus          : bomb_countdown_ctrl_if.slave (pulses in, register ctrl out, status)
// State/attempts/flags are registered; cnt_ctrl/cnt_load are combinational
// so the register and this FSM move on the same edge.
module bomb_countdown_ctrl
  import bomb_pkg::*;
#(
  parameter int         WIDTH        = 8,
  parameter int         DEFAULT_TIME = 30,
  parameter int         MAX_TIME     = 99,
  parameter logic [3:0] SECRET_CODE  = 4'hA,
  parameter int         MAX_ATTEMPTS = 3
) (
  input logic                  clk,
  input logic                  async_nreset,
  bomb_countdown_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_T  = WIDTH'(MAX_TIME);
  localparam logic [WIDTH-1:0] DEF_T  = WIDTH'(DEFAULT_TIME);
  localparam logic [1:0]       ATT_MX = 2'(MAX_ATTEMPTS);

  state_t     st_q, st_d;
  logic [1:0] att_q, att_d;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      st_q  <= IDLE;
      att_q <= ATT_MX;
    end else begin
      st_q  <= st_d;
      att_q <= att_d;
    end
  end

  always_comb begin
    st_d         = st_q;
    att_d        = att_q;
    bus.cnt_ctrl = NONE;
    bus.cnt_load = '0;
    case (st_q)
      IDLE: begin
        // An arm at zero time is treated as no press, so inc/dec still act.
        if (bus.btn_arm && bus.cnt_value != '0) begin
          st_d  = ARMED;
          att_d = ATT_MX;
        end else if (bus.btn_inc) begin
          if (bus.cnt_value < MAX_T) bus.cnt_ctrl = INCR;
        end else if (bus.btn_dec) begin
          if (bus.cnt_value != '0) bus.cnt_ctrl = DECR;
        end
      end
      ARMED: begin
        // Disarm attempts take the cycle; a coincident tick is dropped.
        if (bus.btn_disarm && bus.code_in == SECRET_CODE) begin
          st_d = DEFUSED;
        end else if (bus.btn_disarm) begin
          if (att_q == 2'd1) begin
            st_d  = EXPLODED;
            att_d = 2'd0;
          end else begin
            att_d        = att_q - 2'd1;
            bus.cnt_ctrl = LOAD;
            bus.cnt_load = bus.cnt_value >> 1;
          end
        end else if (bus.tick) begin
          // The zero second is shown for a full tick before exploding.
          if (bus.cnt_value == '0) st_d = EXPLODED;
          else                     bus.cnt_ctrl = DECR;
        end
      end
      EXPLODED, DEFUSED: begin
        if (bus.btn_clear) begin
          st_d         = IDLE;
          att_d        = ATT_MX;
          bus.cnt_ctrl = LOAD;
          bus.cnt_load = DEF_T;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign bus.armed         = (st_q == ARMED);
  assign bus.exploded      = (st_q == EXPLODED);
  assign bus.defused       = (st_q == DEFUSED);
  assign bus.attempts_left = att_q;

endmodule
